// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch metric unit for a rate 1/N Viterbi decoder.
// Stage 1 registers per-bit distances against expected 0 and expected 1;
// stage 2 sums them into all 2^N codeword metrics and picks the minimum.
// Valid/ready flow control lets a two-symbol backlog sit in the pipe.
module bmc_soft_pipe #(
  parameter  int N     = 2,
  parameter  int Q     = 3,
  parameter  int CNT_W = 16,
  localparam int MW    = Q + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*Q-1:0]          rx_soft,
  input  logic [N-1:0]            erase,
  input  logic                    hard_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**N)*MW-1:0]    bm,
  output logic [N-1:0]            best_cw,
  output logic [CNT_W-1:0]        sym_cnt
);

  localparam int NCW = 2**N;
  localparam logic [Q-1:0] QMAX = '1;

  logic [Q-1:0]       d0_n [N];
  logic [Q-1:0]       d1_n [N];
  logic [Q-1:0]       d0_q [N];
  logic [Q-1:0]       d1_q [N];
  logic               s1_valid;
  logic               s2_load;
  logic               s1_adv;
  logic [NCW*MW-1:0]  bm_n;
  logic [N-1:0]       best_n;

  // Handshake: S2 takes a new set when empty or draining; S1 moves when empty or S2 takes.
  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_load;
    in_ready = s1_adv;
  end

  // Per-bit distances for the incoming symbol; erased bits contribute nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      d0_n[i] = '0;
      d1_n[i] = '0;
      if (!erase[i]) begin
        if (hard_mode) begin
          d0_n[i] = Q'(rx_soft[i*Q+Q-1]);
          d1_n[i] = Q'(!rx_soft[i*Q+Q-1]);
        end else begin
          d0_n[i] = rx_soft[i*Q +: Q];
          d1_n[i] = QMAX - rx_soft[i*Q +: Q];
        end
      end
    end
  end

  // Codeword metrics from the stored distances and lowest-index minimum search.
  always_comb begin
    logic [MW-1:0] acc;
    logic [MW-1:0] best_val;
    bm_n     = '0;
    best_n   = '0;
    best_val = '0;
    for (int c = 0; c < NCW; c++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        if (((c >> i) & 1) != 0)
          acc = acc + MW'(d1_q[i]);
        else
          acc = acc + MW'(d0_q[i]);
      end
      bm_n[c*MW +: MW] = acc;
      // Strict compare keeps the earliest codeword on ties.
      if (c == 0 || acc < best_val) begin
        best_val = acc;
        best_n   = N'(c);
      end
    end
  end

  // Stage 1: capture distances on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        d0_q[i] <= '0;
        d1_q[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          d0_q[i] <= d0_n[i];
          d1_q[i] <= d1_n[i];
        end
      end
    end
  end

  // Stage 2: register metrics and best index; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bm        <= '0;
      best_cw   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        bm      <= bm_n;
        best_cw <= best_n;
      end
    end
  end

  // Delivered-set counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sym_cnt <= '0;
    else if (out_valid && out_ready)
      sym_cnt <= sym_cnt + 1'b1;
  end

endmodule
